// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: handshaked inter-stage register with flush, debug freeze
// and saturating stall counter; define PIPE_STAGE_BUF_SKID_EN for a skid entry.
module pipe_stage_buf #(
    parameter int NB_REG   = 32,
    parameter int NB_ADDR  = 5,
    parameter int NB_CTRL  = 9,
    parameter int NB_STALL = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_dunit_clk_en,
    input  logic                i_flush,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [NB_REG-1:0]   i_pc_eight,
    input  logic [NB_REG-1:0]   i_alu_result,
    input  logic [NB_REG-1:0]   i_w_data,
    input  logic [NB_ADDR-1:0]  i_data_addr,
    input  logic [NB_CTRL-1:0]  i_ctrl,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [NB_REG-1:0]   o_pc_eight,
    output logic [NB_REG-1:0]   o_alu_result,
    output logic [NB_REG-1:0]   o_w_data,
    output logic [NB_ADDR-1:0]  o_data_addr,
    output logic [NB_CTRL-1:0]  o_ctrl,
    output logic [1:0]          o_count,
    output logic [NB_STALL-1:0] o_stall_cnt
);

    localparam int NB_PL = 3 * NB_REG + NB_ADDR + NB_CTRL;

    logic [NB_PL-1:0]    in_pl;
    logic [NB_PL-1:0]    m_pl;
    logic                m_valid;
    logic [NB_CTRL-1:0]  m_ctrl;
    logic [NB_STALL-1:0] stall_cnt;
    logic                accept;
    logic                consume;

    assign in_pl = {i_pc_eight, i_alu_result, i_w_data,
                    i_data_addr, i_ctrl};

    assign {o_pc_eight, o_alu_result, o_w_data,
            o_data_addr, m_ctrl} = m_pl;

    assign accept  = i_valid & o_ready & i_dunit_clk_en & ~i_flush;
    assign consume = m_valid & i_ready & i_dunit_clk_en;

    // Bubbles must never carry write-enables downstream
    assign o_valid     = m_valid;
    assign o_ctrl      = m_valid ? m_ctrl : '0;
    assign o_stall_cnt = stall_cnt;

`ifdef PIPE_STAGE_BUF_SKID_EN

    logic             s_valid;
    logic [NB_PL-1:0] s_pl;

    // Depends only on state, reset and freeze: no path from i_ready
    assign o_ready = ~s_valid & ~i_reset & i_dunit_clk_en;
    assign o_count = {m_valid & s_valid, m_valid ^ s_valid};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_pl    <= '0;
            s_pl    <= '0;
        end else if (i_dunit_clk_en) begin
            if (i_flush) begin
                m_valid <= 1'b0;
                s_valid <= 1'b0;
            end else if (consume && s_valid) begin
                m_pl    <= s_pl;
                s_valid <= 1'b0;
            end else if (!m_valid || consume) begin
                m_valid <= accept;
                if (accept)
                    m_pl <= in_pl;
            end else if (accept) begin
                s_pl    <= in_pl;
                s_valid <= 1'b1;
            end
        end
    end

`else

    assign o_ready = (~m_valid | i_ready) & ~i_reset & i_dunit_clk_en;
    assign o_count = {1'b0, m_valid};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            m_valid <= 1'b0;
            m_pl    <= '0;
        end else if (i_dunit_clk_en) begin
            if (i_flush) begin
                m_valid <= 1'b0;
            end else if (accept) begin
                m_valid <= 1'b1;
                m_pl    <= in_pl;
            end else if (consume) begin
                m_valid <= 1'b0;
            end
        end
    end

`endif

    always_ff @(posedge i_clk) begin
        if (i_reset)
            stall_cnt <= '0;
        else if (m_valid && !i_ready && i_dunit_clk_en && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed vectors for pipe_stage_buf
// (NB_STALL=4 so saturation is reachable quickly).
module tb_pipe_stage_buf;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_dunit_clk_en;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_pc_eight;
    logic [31:0] i_alu_result;
    logic [31:0] i_w_data;
    logic [4:0]  i_data_addr;
    logic [8:0]  i_ctrl;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_pc_eight;
    logic [31:0] o_alu_result;
    logic [31:0] o_w_data;
    logic [4:0]  o_data_addr;
    logic [8:0]  o_ctrl;
    logic [1:0]  o_count;
    logic [3:0]  o_stall_cnt;

    int n_chk = 0;
    int n_err = 0;
    int exp_stall = 0;

    always #5 i_clk = ~i_clk;

    pipe_stage_buf #(
        .NB_REG(32), .NB_ADDR(5), .NB_CTRL(9), .NB_STALL(4)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_dunit_clk_en(i_dunit_clk_en),
        .i_flush(i_flush),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_pc_eight(i_pc_eight),
        .i_alu_result(i_alu_result),
        .i_w_data(i_w_data),
        .i_data_addr(i_data_addr),
        .i_ctrl(i_ctrl),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_pc_eight(o_pc_eight),
        .o_alu_result(o_alu_result),
        .o_w_data(o_w_data),
        .o_data_addr(o_data_addr),
        .o_ctrl(o_ctrl),
        .o_count(o_count),
        .o_stall_cnt(o_stall_cnt)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic v, input logic [31:0] a,
                        input logic [8:0] c);
        i_valid      = v;
        i_alu_result = a;
        i_pc_eight   = a + 32'd8;
        i_w_data     = a ^ 32'hFFFF_0000;
        i_data_addr  = a[4:0];
        i_ctrl       = c;
    endtask

    task automatic stall_tick();
        tick();
        if (exp_stall < 15)
            exp_stall++;
    endtask

    initial begin
        i_reset        = 1'b1;
        i_dunit_clk_en = 1'b1;
        i_flush        = 1'b0;
        i_ready        = 1'b0;
        send(1'b0, 32'd0, 9'd0);

        // reset then idle
        tick();
        tick();
        i_reset = 1'b0;
        #1;
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_ctrl", {23'd0, o_ctrl}, 32'd0);
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_count", {30'd0, o_count}, 32'd0);
        check("rst_stall", {28'd0, o_stall_cnt}, 32'd0);
        check("rst_alu", o_alu_result, 32'd0);

        // streaming 0..7
        i_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send(1'b1, k, 9'(k + 1));
            #1;
            check("str_ready", {31'd0, o_ready}, 32'd1);
            tick();
            check("str_valid", {31'd0, o_valid}, 32'd1);
            check("str_alu", o_alu_result, k);
            check("str_ctrl", {23'd0, o_ctrl}, k + 1);
            check("str_count", {30'd0, o_count}, 32'd1);
        end
        check("str_pc", o_pc_eight, 32'd15);
        check("str_addr", {27'd0, o_data_addr}, 32'd7);
        check("str_wdata", o_w_data, 32'hFFFF_0007);
        send(1'b0, 32'd99, 9'h1FF);
        tick();
        check("bub_valid", {31'd0, o_valid}, 32'd0);
        check("bub_ctrl", {23'd0, o_ctrl}, 32'd0);
        check("bub_alu_hold", o_alu_result, 32'd7);
        check("bub_count", {30'd0, o_count}, 32'd0);
        check("bub_stall", {28'd0, o_stall_cnt}, 32'd0);

        // backpressure
        i_ready = 1'b0;
        send(1'b1, 32'hA, 9'h00A);
        tick();
        check("bp_alu_a", o_alu_result, 32'hA);
`ifdef PIPE_STAGE_BUF_SKID_EN
        check("bp_ready1", {31'd0, o_ready}, 32'd1);
        send(1'b1, 32'hB, 9'h00B);
        stall_tick();
        check("bp_count2", {30'd0, o_count}, 32'd2);
        check("bp_ready0", {31'd0, o_ready}, 32'd0);
        send(1'b1, 32'hC, 9'h00C);
        stall_tick();
        stall_tick();
        check("bp_alu_m", o_alu_result, 32'hA);
        check("bp_count_h", {30'd0, o_count}, 32'd2);
        check("bp_stall", {28'd0, o_stall_cnt}, exp_stall);
        i_ready = 1'b1;
        tick();
        check("bp_out_b", o_alu_result, 32'hB);
        check("bp_cnt_b", {30'd0, o_count}, 32'd1);
        check("bp_rdy_b", {31'd0, o_ready}, 32'd1);
        tick();
        check("bp_out_c", o_alu_result, 32'hC);
        check("bp_cnt_c", {30'd0, o_count}, 32'd1);
`else
        #1;
        check("bp_ready0", {31'd0, o_ready}, 32'd0);
        send(1'b1, 32'hB, 9'h00B);
        stall_tick();
        stall_tick();
        check("bp_alu_m", o_alu_result, 32'hA);
        check("bp_count_h", {30'd0, o_count}, 32'd1);
        check("bp_stall", {28'd0, o_stall_cnt}, exp_stall);
        i_ready = 1'b1;
        #1;
        check("bp_ready_c", {31'd0, o_ready}, 32'd1);
        tick();
        check("bp_out_b", o_alu_result, 32'hB);
        check("bp_cnt_b", {30'd0, o_count}, 32'd1);
`endif
        send(1'b0, 32'd0, 9'd0);
        tick();
        check("bp_drain", {31'd0, o_valid}, 32'd0);
        check("bp_stall2", {28'd0, o_stall_cnt}, exp_stall);

        // flush
        i_ready = 1'b0;
        send(1'b1, 32'h11, 9'h1FF);
        tick();
`ifdef PIPE_STAGE_BUF_SKID_EN
        send(1'b1, 32'h22, 9'h1FF);
        stall_tick();
        check("fl_count2", {30'd0, o_count}, 32'd2);
`endif
        check("fl_ctrl_pre", {23'd0, o_ctrl}, 32'h1FF);
        send(1'b1, 32'h33, 9'h1FF);
        i_flush = 1'b1;
        stall_tick();
        check("fl_valid", {31'd0, o_valid}, 32'd0);
        check("fl_ctrl", {23'd0, o_ctrl}, 32'd0);
        check("fl_count", {30'd0, o_count}, 32'd0);
        check("fl_alu_hold", o_alu_result, 32'h11);
        check("fl_stall", {28'd0, o_stall_cnt}, exp_stall);
        i_flush = 1'b0;
        send(1'b0, 32'd0, 9'd0);
        tick();
        check("fl_dropped", {31'd0, o_valid}, 32'd0);

        // debug freeze
        send(1'b1, 32'hD, 9'h055);
        tick();
        send(1'b1, 32'h77, 9'h0AA);
        i_dunit_clk_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_ready = k[0];
            i_flush = k[1];
            #1;
            check("dz_ready", {31'd0, o_ready}, 32'd0);
            tick();
            check("dz_valid", {31'd0, o_valid}, 32'd1);
            check("dz_alu", o_alu_result, 32'hD);
            check("dz_ctrl", {23'd0, o_ctrl}, 32'h055);
            check("dz_count", {30'd0, o_count}, 32'd1);
            check("dz_stall", {28'd0, o_stall_cnt}, exp_stall);
        end
        i_dunit_clk_en = 1'b1;
        i_flush = 1'b0;
        i_ready = 1'b0;
        send(1'b0, 32'd0, 9'd0);

        // stall counter saturation
        for (int k = 0; k < 20; k++) begin
            stall_tick();
            check("sat_stall", {28'd0, o_stall_cnt}, exp_stall);
        end
        check("sat_final", {28'd0, o_stall_cnt}, 32'd15);
        check("sat_valid", {31'd0, o_valid}, 32'd1);

        // reset mid-transfer
        send(1'b1, 32'h55, 9'h1FF);
        i_reset = 1'b1;
        #1;
        check("mr_ready", {31'd0, o_ready}, 32'd0);
        tick();
        check("mr_valid", {31'd0, o_valid}, 32'd0);
        check("mr_count", {30'd0, o_count}, 32'd0);
        check("mr_stall", {28'd0, o_stall_cnt}, 32'd0);
        check("mr_alu", o_alu_result, 32'd0);
        i_reset = 1'b0;
        send(1'b0, 32'd0, 9'd0);
        #1;
        check("mr_ready1", {31'd0, o_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
